// File: rtl/data_bus_arbiter_if.sv
// Shared data-port bundle: CPU and debug requester handshakes plus the memory/IO port.
// The arbiter takes the slave view; the environment takes the master view.
interface data_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_size;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [2:0]        dbg_size;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_value;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [2:0]        mem_data_size;
    logic [DATA_W-1:0] mem_read_value;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size,
        output dbg_ack, dbg_rdata,
        output mem_address, mem_write_value, mem_read_en, mem_write_en, mem_data_size,
        input  mem_read_value
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_size,
        input  dbg_ack, dbg_rdata,
        input  mem_address, mem_write_value, mem_read_en, mem_write_en, mem_data_size,
        output mem_read_value
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing the data memory/IO port between the CPU load/store path
// and the debug loader. Each access is IDLE -> ACCESS -> RESP, three cycles.
module data_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    data_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              owner, owner_nxt;
    logic              win;
    logic              req_we, req_we_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic [DATA_W-1:0] req_wdata, req_wdata_nxt;
    logic [2:0]        req_size, req_size_nxt;
    logic [DATA_W-1:0] rdata_reg, rdata_nxt, rdata_load;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_nxt;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_nxt;
    logic              cpu_ack_q, cpu_ack_nxt;
    logic              dbg_ack_q, dbg_ack_nxt;
    logic              rd_en_q, rd_en_nxt;
    logic              wr_en_q, wr_en_nxt;

    // State, request capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= DBG;
            owner       <= CPU;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_size    <= '0;
            rdata_reg   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            owner       <= owner_nxt;
            req_we      <= req_we_nxt;
            req_addr    <= req_addr_nxt;
            req_wdata   <= req_wdata_nxt;
            req_size    <= req_size_nxt;
            rdata_reg   <= rdata_nxt;
            cpu_rdata_q <= cpu_rdata_nxt;
            dbg_rdata_q <= dbg_rdata_nxt;
            cpu_ack_q   <= cpu_ack_nxt;
            dbg_ack_q   <= dbg_ack_nxt;
            rd_en_q     <= rd_en_nxt;
            wr_en_q     <= wr_en_nxt;
        end
    end

    // Next state, arbitration and next values of the registered outputs
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        req_we_nxt     = req_we;
        req_addr_nxt   = req_addr;
        req_wdata_nxt  = req_wdata;
        req_size_nxt   = req_size;
        rdata_nxt      = rdata_reg;
        cpu_rdata_nxt  = cpu_rdata_q;
        dbg_rdata_nxt  = dbg_rdata_q;
        cpu_ack_nxt    = 1'b0;
        dbg_ack_nxt    = 1'b0;
        rd_en_nxt      = 1'b0;
        wr_en_nxt      = 1'b0;
        // On a tie the requester that did not win last time gets the port
        win            = (bus.cpu_req && bus.dbg_req) ? ~last_grant : bus.dbg_req;
        rdata_load     = req_we ? rdata_reg : bus.mem_read_value;

        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    owner_nxt      = win;
                    last_grant_nxt = win;
                    req_we_nxt     = (win == DBG) ? bus.dbg_we    : bus.cpu_we;
                    req_addr_nxt   = (win == DBG) ? bus.dbg_addr  : bus.cpu_addr;
                    req_wdata_nxt  = (win == DBG) ? bus.dbg_wdata : bus.cpu_wdata;
                    req_size_nxt   = (win == DBG) ? bus.dbg_size  : bus.cpu_size;
                    rd_en_nxt      = ~req_we_nxt;
                    wr_en_nxt      = req_we_nxt;
                    state_nxt      = ACCESS;
                end
            end
            ACCESS: begin
                rdata_nxt = rdata_load;
                if (owner == DBG) begin
                    dbg_rdata_nxt = rdata_load;
                    dbg_ack_nxt   = 1'b1;
                end else begin
                    cpu_rdata_nxt = rdata_load;
                    cpu_ack_nxt   = 1'b1;
                end
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.cpu_ack         = cpu_ack_q;
    assign bus.dbg_ack         = dbg_ack_q;
    assign bus.cpu_rdata       = cpu_rdata_q;
    assign bus.dbg_rdata       = dbg_rdata_q;
    assign bus.cpu_stall       = bus.cpu_req & ~cpu_ack_q;
    assign bus.mem_address     = req_addr;
    assign bus.mem_write_value = req_wdata;
    assign bus.mem_data_size   = req_size;
    assign bus.mem_read_en     = rd_en_q;
    assign bus.mem_write_en    = wr_en_q;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: stimulus pushes expected acks and memory-port
// accesses into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_data_bus_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic        dbg;
        logic [31:0] rdata;
    } ack_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } acc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic preload = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cpu_acks = 0;
    logic prev_ack = 1'b0;
    logic prev_en  = 1'b0;

    ack_t ack_q[$];
    acc_t mem_q[$];
    int   ack_cyc[$];
    logic [31:0] mem_arr [0:63];

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word-addressed memory model: combinational read, write on the clock edge
    assign bus.mem_read_value = mem_arr[bus.mem_address[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
            mem_arr[4] <= 32'hDEADBEEF;
            mem_arr[8] <= 32'hCAFEF00D;
        end else if (bus.mem_write_en) begin
            mem_arr[bus.mem_address[7:2]] <= bus.mem_write_value;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input logic dbg, input logic [31:0] rdata);
        ack_t a;
        a.dbg = dbg;
        a.rdata = rdata;
        ack_q.push_back(a);
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size);
        acc_t m;
        m.we = we;
        m.addr = addr;
        m.wdata = wdata;
        m.size = size;
        mem_q.push_back(m);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        ack_t ea;
        acc_t em;
        if (!rst_n) begin
            prev_ack <= 1'b0;
            prev_en  <= 1'b0;
        end else begin
            if (bus.cpu_ack || bus.dbg_ack) begin
                check("ack_exclusive", 64'(bus.cpu_ack & bus.dbg_ack), 64'(0));
                check("ack_single_cycle", 64'(prev_ack), 64'(0));
                ack_cyc.push_back(cyc);
                check("ack_expected", 64'(ack_q.size() != 0), 64'(1));
                if (ack_q.size() != 0) begin
                    ea = ack_q.pop_front();
                    check("ack_owner", 64'(bus.dbg_ack), 64'(ea.dbg));
                    check("ack_rdata", 64'(ea.dbg ? bus.dbg_rdata : bus.cpu_rdata), 64'(ea.rdata));
                end
            end
            if (bus.mem_read_en || bus.mem_write_en) begin
                check("mem_en_exclusive", 64'(bus.mem_read_en & bus.mem_write_en), 64'(0));
                check("mem_en_single_cycle", 64'(prev_en), 64'(0));
                check("mem_expected", 64'(mem_q.size() != 0), 64'(1));
                if (mem_q.size() != 0) begin
                    em = mem_q.pop_front();
                    check("mem_we", 64'(bus.mem_write_en), 64'(em.we));
                    check("mem_address", 64'(bus.mem_address), 64'(em.addr));
                    check("mem_write_value", 64'(bus.mem_write_value), 64'(em.wdata));
                    check("mem_data_size", 64'(bus.mem_data_size), 64'(em.size));
                end
            end
            prev_ack <= bus.cpu_ack | bus.dbg_ack;
            prev_en  <= bus.mem_read_en | bus.mem_write_en;
        end
    end

    task automatic cpu_set(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size);
        bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_size = size;
    endtask

    task automatic dbg_set(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size);
        bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; bus.dbg_size = size;
    endtask

    task automatic wait_ack(input logic is_dbg);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (is_dbg ? bus.dbg_ack : bus.cpu_ack) break;
        end
        check(is_dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 64'(k < 20), 64'(1));
    endtask

    task automatic cpu_hold(input int n);
        bus.cpu_req = 1'b1;
        repeat (n) begin
            wait_ack(1'b0);
            cpu_acks++;
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic dbg_hold(input int n);
        bus.dbg_req = 1'b1;
        repeat (n) wait_ack(1'b1);
        @(posedge clk); #1;
        bus.dbg_req = 1'b0;
    endtask

    task automatic do_reset(input logic load);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        preload = load;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ack", 64'(bus.cpu_ack), 64'(0));
        check("rst_dbg_ack", 64'(bus.dbg_ack), 64'(0));
        check("rst_mem_en", 64'({bus.mem_read_en, bus.mem_write_en}), 64'(0));
        check("rst_mem_address", 64'(bus.mem_address), 64'(0));
        check("rst_cpu_stall", 64'(bus.cpu_stall), 64'(0));
        preload = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        cpu_set(1'b0, 32'h0, 32'h0, 3'd0);
        dbg_set(1'b0, 32'h0, 32'h0, 3'd0);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        #2;
        do_reset(1'b1);

        // CPU load with per-cycle stall/enable/ack checks
        @(posedge clk); #1;
        cpu_set(1'b0, 32'h10, 32'h0, 3'd2);
        exp_mem(1'b0, 32'h10, 32'h0, 3'd2);
        exp_ack(1'b0, 32'hDEADBEEF);
        bus.cpu_req = 1'b1;
        @(negedge clk);
        check("load_c1_stall", 64'(bus.cpu_stall), 64'(1));
        check("load_c1_ack", 64'(bus.cpu_ack), 64'(0));
        @(negedge clk);
        check("load_c2_stall", 64'(bus.cpu_stall), 64'(1));
        check("load_c2_read_en", 64'(bus.mem_read_en), 64'(1));
        @(negedge clk);
        check("load_c3_ack", 64'(bus.cpu_ack), 64'(1));
        check("load_c3_stall", 64'(bus.cpu_stall), 64'(0));
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;

        // Loader store, then CPU reads it back
        dbg_set(1'b1, 32'h40, 32'h12345678, 3'd2);
        exp_mem(1'b1, 32'h40, 32'h12345678, 3'd2);
        exp_ack(1'b1, 32'hDEADBEEF);
        dbg_hold(1);
        cpu_set(1'b0, 32'h40, 32'h0, 3'd0);
        exp_mem(1'b0, 32'h40, 32'h0, 3'd0);
        exp_ack(1'b0, 32'h12345678);
        cpu_hold(1);

        // Request inputs changed during ACCESS are ignored
        cpu_set(1'b0, 32'h10, 32'hA5A5A5A5, 3'd1);
        exp_mem(1'b0, 32'h10, 32'hA5A5A5A5, 3'd1);
        exp_ack(1'b0, 32'hDEADBEEF);
        bus.cpu_req = 1'b1;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.mem_read_en) break;
        end
        check("chg_access_seen", 64'(k < 10), 64'(1));
        #2;
        cpu_set(1'b0, 32'h20, 32'h5A5A5A5A, 3'd3);
        #1;
        check("chg_addr_access", 64'(bus.mem_address), 64'(32'h10));
        wait_ack(1'b0);
        check("chg_addr_resp", 64'(bus.mem_address), 64'(32'h10));
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;

        // Tie after reset: CPU, DBG, CPU, DBG at 3-cycle spacing
        do_reset(1'b1);
        cpu_set(1'b0, 32'h20, 32'h0, 3'd2);
        dbg_set(1'b0, 32'h10, 32'h0, 3'd2);
        for (int i = 0; i < 2; i++) begin
            exp_mem(1'b0, 32'h20, 32'h0, 3'd2);
            exp_ack(1'b0, 32'hCAFEF00D);
            exp_mem(1'b0, 32'h10, 32'h0, 3'd2);
            exp_ack(1'b1, 32'hDEADBEEF);
        end
        ack_cyc.delete();
        fork
            cpu_hold(2);
            dbg_hold(2);
        join
        check("tie_ack_count", 64'(ack_cyc.size()), 64'(4));
        for (int i = 1; i < ack_cyc.size(); i++)
            check("tie_ack_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(3));

        // Back-to-back CPU with a loader request raised after the second ack
        cpu_set(1'b0, 32'h10, 32'h0, 3'd2);
        dbg_set(1'b0, 32'h20, 32'h0, 3'd2);
        for (int i = 0; i < 5; i++) begin
            exp_mem(1'b0, (i == 2) ? 32'h20 : 32'h10, 32'h0, 3'd2);
            exp_ack(i == 2, (i == 2) ? 32'hCAFEF00D : 32'hDEADBEEF);
        end
        ack_cyc.delete();
        cpu_acks = 0;
        fork
            cpu_hold(4);
            begin
                int j;
                for (j = 0; j < 30; j++) begin
                    @(negedge clk); #2;
                    if (cpu_acks >= 2) break;
                end
                check("b2b_second_ack", 64'(j < 30), 64'(1));
                dbg_hold(1);
            end
        join
        check("b2b_ack_count", 64'(ack_cyc.size()), 64'(5));
        for (int i = 1; i < ack_cyc.size(); i++)
            check("b2b_ack_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(3));

        // Reset during a loader write's ACCESS cycle drops the write
        dbg_set(1'b1, 32'h80, 32'hBAD0BAD0, 3'd2);
        exp_mem(1'b1, 32'h80, 32'hBAD0BAD0, 3'd2);
        bus.dbg_req = 1'b1;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.mem_write_en) break;
        end
        check("rstw_access_seen", 64'(k < 10), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_write_en", 64'(bus.mem_write_en), 64'(0));
        check("rstw_read_en", 64'(bus.mem_read_en), 64'(0));
        check("rstw_acks", 64'({bus.cpu_ack, bus.dbg_ack}), 64'(0));
        @(posedge clk); #1;
        bus.dbg_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_set(1'b0, 32'h80, 32'h0, 3'd2);
        exp_mem(1'b0, 32'h80, 32'h0, 3'd2);
        exp_ack(1'b0, 32'h0);
        cpu_hold(1);

        repeat (3) @(posedge clk);
        check("ack_queue_drained", 64'(ack_q.size()), 64'(0));
        check("mem_queue_drained", 64'(mem_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
